player_life_ctrl: RTL and testbench



---
 rtl/player_life_ctrl_pkg.sv | 31 +++
 rtl/player_life_ctrl_frame_countdown.sv | 56 +++++
 rtl/player_life_ctrl.sv | 143 ++++++++++++++
 tb/tb_player_life_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/player_life_ctrl_pkg.sv
// ============================================================================
// Module   : player_life_ctrl_pkg
// Purpose  : Shared game types, life bound and thermometer encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package player_life_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ALIVE     = 2'd1,
    ST_INVULN    = 2'd2,
    ST_GAME_OVER = 2'd3
  } game_state_t;

  localparam int GAME_MAX_LIVES = 4;

  // Bit i set iff lives > i; also drives the life-icon bitmap.
  function automatic logic [GAME_MAX_LIVES-1:0] thermometer(input int lives);
    logic [GAME_MAX_LIVES-1:0] m;
    m = '0;
    for (int i = 0; i < GAME_MAX_LIVES; i++) begin
      m[i] = (lives > i);
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/player_life_ctrl_frame_countdown.sv
// ============================================================================
// Module   : frame_countdown
// Purpose  : Loadable frame down-counter with zero flag and blink-phase strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_countdown #(
  parameter int WIDTH        = 8,
  parameter int BLINK_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  output logic             zero_o,
  output logic             expire_o,
  output logic             blink_o
);

  localparam int PW = $clog2(BLINK_FRAMES + 1);

  logic [WIDTH-1:0] count_q;
  logic [PW-1:0]    phase_q;
  logic             w_step;
  logic             w_wrap;

  assign w_step = tick_i && (count_q != '0);
  assign w_wrap = (phase_q == PW'(BLINK_FRAMES - 1));

  // phase_q counts elapsed ticks modulo BLINK_FRAMES since the last load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
      phase_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
      phase_q <= '0;
    end else if (w_step) begin
      count_q <= count_q - WIDTH'(1);
      phase_q <= w_wrap ? '0 : phase_q + PW'(1);
    end
  end

  assign zero_o   = (count_q == '0);
  assign expire_o = w_step && (count_q == WIDTH'(1));
  assign blink_o  = w_step && w_wrap;

endmodule

`default_nettype wire

// File: rtl/player_life_ctrl.sv
// ============================================================================
// Module   : player_life_ctrl
// Purpose  : Player lives manager, hit sequencer and invulnerability blink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_life_ctrl
  import player_life_ctrl_pkg::*;
#(
  parameter int MAX_LIVES     = GAME_MAX_LIVES,
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           playGame,
  input  logic                           startOfFrame,
  input  logic                           shotHitPlayer,
  input  logic                           extraLife,
  output logic [MAX_LIVES-1:0]           lifeMask,
  output logic [$clog2(MAX_LIVES+1)-1:0] livesCount,
  output logic                           invulnerable,
  output logic                           playerVisible,
  output logic                           gameLose
);

  localparam int                   LW        = $clog2(MAX_LIVES + 1);
  localparam logic [MAX_LIVES-1:0] INIT_MASK = thermometer(INIT_LIVES);

  game_state_t          state_q;
  logic [LW-1:0]        lives_q;
  logic [LW-1:0]        lives_d;
  logic [MAX_LIVES-1:0] mask_q;
  logic                 invuln_q;
  logic                 visible_q;
  logic                 lose_q;
  logic                 shot_prev_q;

  logic w_hit;
  logic w_extra_ok;
  logic w_load;
  logic w_tick;
  logic w_zero;
  logic w_expire;
  logic w_blink;

  assign w_hit      = shotHitPlayer & ~shot_prev_q;
  assign w_extra_ok = extraLife && (lives_q < LW'(MAX_LIVES));

  // A hit together with an extra life leaves the count untouched.
  always_comb begin
    lives_d = lives_q;
    if (!playGame || state_q == ST_IDLE) begin
      lives_d = LW'(INIT_LIVES);
    end else if (state_q == ST_ALIVE && w_hit) begin
      if (!extraLife) lives_d = lives_q - LW'(1);
    end else if (state_q == ST_ALIVE || state_q == ST_INVULN) begin
      if (w_extra_ok) lives_d = lives_q + LW'(1);
    end
  end

  assign w_load = playGame && (state_q == ST_ALIVE) && w_hit && (lives_d != '0);
  assign w_tick = startOfFrame && (state_q == ST_INVULN) && !w_zero;

  frame_countdown #(
    .WIDTH        (FRAME_CNT_W),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_countdown (
    .clk        (clk),
    .rst        (reset),
    .clear_i    (!playGame),
    .load_i     (w_load),
    .load_val_i (FRAME_CNT_W'(INVULN_FRAMES)),
    .tick_i     (w_tick),
    .zero_o     (w_zero),
    .expire_o   (w_expire),
    .blink_o    (w_blink)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lives_q     <= LW'(INIT_LIVES);
      mask_q      <= INIT_MASK;
      invuln_q    <= 1'b0;
      visible_q   <= 1'b1;
      lose_q      <= 1'b0;
      shot_prev_q <= 1'b0;
    end else begin
      shot_prev_q <= shotHitPlayer;
      lives_q     <= lives_d;
      mask_q      <= thermometer(int'(lives_d));
      if (!playGame) begin
        state_q   <= ST_IDLE;
        invuln_q  <= 1'b0;
        visible_q <= 1'b1;
        lose_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_ALIVE;
          ST_ALIVE: begin
            if (w_hit) begin
              visible_q <= 1'b0;
              if (lives_d != '0) begin
                state_q  <= ST_INVULN;
                invuln_q <= 1'b1;
              end else begin
                state_q <= ST_GAME_OVER;
                lose_q  <= 1'b1;
              end
            end
          end
          ST_INVULN: begin
            if (w_expire) begin
              state_q   <= ST_ALIVE;
              invuln_q  <= 1'b0;
              visible_q <= 1'b1;
            end else if (w_blink) begin
              visible_q <= ~visible_q;
            end
          end
          ST_GAME_OVER: begin
            lose_q    <= 1'b1;
            visible_q <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign lifeMask      = mask_q;
  assign livesCount    = lives_q;
  assign invulnerable  = invuln_q;
  assign playerVisible = visible_q;
  assign gameLose      = lose_q;

endmodule

`default_nettype wire

// File: tb/tb_player_life_ctrl.sv
// ============================================================================
// Module   : tb_player_life_ctrl
// Purpose  : Self-checking bench: directed table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_player_life_ctrl;

  localparam int INIT   = 3;
  localparam int MAXL   = 4;
  localparam int INVULN = 4;
  localparam int BLINK  = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ALIVE = 1;
  localparam int M_INV   = 2;
  localparam int M_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       playGame = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       shotHitPlayer = 1'b0;
  logic       extraLife = 1'b0;
  logic [3:0] lifeMask;
  logic [2:0] livesCount;
  logic       invulnerable;
  logic       playerVisible;
  logic       gameLose;

  int checks = 0;
  int errors = 0;

  player_life_ctrl #(
    .INIT_LIVES    (INIT),
    .INVULN_FRAMES (INVULN),
    .BLINK_FRAMES  (BLINK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .playGame      (playGame),
    .startOfFrame  (startOfFrame),
    .shotHitPlayer (shotHitPlayer),
    .extraLife     (extraLife),
    .lifeMask      (lifeMask),
    .livesCount    (livesCount),
    .invulnerable  (invulnerable),
    .playerVisible (playerVisible),
    .gameLose      (gameLose)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: lives as an integer, window as frames remaining.
  int m_mode, m_lives, m_left;
  bit m_inv, m_vis, m_lose, m_prev;
  bit model_on = 1'b0;

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_lives = INIT;
    m_left  = 0;
    m_inv   = 1'b0;
    m_vis   = 1'b1;
    m_lose  = 1'b0;
    m_prev  = 1'b0;
  endfunction

  function automatic void model_step(bit pg, bit sof, bit hit, bit xl);
    bit rise;
    rise   = hit && !m_prev;
    m_prev = hit;
    if (!pg) begin
      model_reset();
      m_prev = hit;
      return;
    end
    case (m_mode)
      M_IDLE: m_mode = M_ALIVE;
      M_ALIVE: begin
        if (rise) begin
          if (!xl) m_lives = m_lives - 1;
          m_vis = 1'b0;
          if (m_lives == 0) begin
            m_mode = M_OVER;
            m_lose = 1'b1;
          end else begin
            m_mode = M_INV;
            m_left = INVULN;
            m_inv  = 1'b1;
          end
        end else if (xl && m_lives < MAXL) begin
          m_lives = m_lives + 1;
        end
      end
      M_INV: begin
        if (xl && m_lives < MAXL) m_lives = m_lives + 1;
        if (sof && m_left > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode = M_ALIVE;
            m_inv  = 1'b0;
            m_vis  = 1'b1;
          end else if ((INVULN - m_left) % BLINK == 0) begin
            m_vis = !m_vis;
          end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string nm, input logic [2:0] el, input logic [3:0] em,
                       input logic ei, input logic ev, input logic eg);
    checks++;
    if ({livesCount, lifeMask, invulnerable, playerVisible, gameLose} !== {el, em, ei, ev, eg}) begin
      errors++;
      $display("FAIL %s: got lives=%0d mask=%b inv=%b vis=%b lose=%b, want lives=%0d mask=%b inv=%b vis=%b lose=%b",
               nm, livesCount, lifeMask, invulnerable, playerVisible, gameLose, el, em, ei, ev, eg);
    end
  endtask

  task automatic cyc(input bit pg, input bit sof, input bit hit, input bit xl);
    playGame      = pg;
    startOfFrame  = sof;
    shotHitPlayer = hit;
    extraLife     = xl;
    @(posedge clk);
    if (model_on) model_step(pg, sof, hit, xl);
    #1;
    if (model_on) check("rand", 3'(m_lives), 4'((1 << m_lives) - 1), m_inv, m_vis, m_lose);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct packed {
    logic       pg, sof, hit, xl;
    logic [2:0] lives;
    logic [3:0] mask;
    logic       inv, vis, lose;
  } vec_t;

  function automatic vec_t mk(bit pg, bit sof, bit hit, bit xl, int lv, bit inv, bit vis, bit lose);
    vec_t v;
    v.pg = pg; v.sof = sof; v.hit = hit; v.xl = xl;
    v.lives = 3'(lv);
    v.mask  = 4'((1 << lv) - 1);
    v.inv = inv; v.vis = vis; v.lose = lose;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    bit hit_lvl;
    // pg sof hit xl | lives inv vis lose
    vecs[0]  = mk(1, 0, 0, 0, 3, 0, 1, 0);
    vecs[1]  = mk(1, 0, 1, 0, 2, 1, 0, 0);
    vecs[2]  = mk(1, 0, 1, 0, 2, 1, 0, 0);
    vecs[3]  = mk(1, 0, 1, 0, 2, 1, 0, 0);
    vecs[4]  = mk(1, 0, 1, 0, 2, 1, 0, 0);
    vecs[5]  = mk(1, 0, 1, 0, 2, 1, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 2, 1, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0, 2, 1, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 2, 1, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 2, 1, 0, 0);
    vecs[10] = mk(1, 1, 0, 0, 2, 1, 1, 0);
    vecs[11] = mk(1, 1, 0, 0, 2, 1, 1, 0);
    vecs[12] = mk(1, 1, 0, 0, 2, 0, 1, 0);
    vecs[13] = mk(1, 0, 0, 1, 3, 0, 1, 0);
    vecs[14] = mk(1, 0, 0, 1, 4, 0, 1, 0);
    vecs[15] = mk(1, 0, 0, 1, 4, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset", 3'd3, 4'b0111, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle", 3'd3, 4'b0111, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].pg, vecs[i].sof, vecs[i].hit, vecs[i].xl);
      check($sformatf("vec%0d", i), vecs[i].lives, vecs[i].mask, vecs[i].inv, vecs[i].vis, vecs[i].lose);
    end

    // Three spaced hits from a fresh game end it; late inputs are ignored.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_idle", 3'd3, 4'b0111, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    frames(INVULN);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("second_hit", 3'd1, 4'b0001, 1'b1, 1'b0, 1'b0);
    frames(INVULN);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("third_hit", 3'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("over_ignores", 3'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("over_to_idle", 3'd3, 4'b0111, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("new_game", 3'd3, 4'b0111, 1'b0, 1'b1, 1'b0);

    // Hit and extra life together at one life.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    frames(INVULN);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    frames(INVULN);
    check("one_life", 3'd1, 4'b0001, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    check("hit_xl_same", 3'd1, 4'b0001, 1'b1, 1'b0, 1'b0);
    frames(1);
    check("hit_xl_frame1", 3'd1, 4'b0001, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-window, observed before any clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 3'd3, 4'b0111, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    playGame = 1'b0; startOfFrame = 1'b0; shotHitPlayer = 1'b0; extraLife = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    model_reset();
    model_on = 1'b1;
    hit_lvl  = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) hit_lvl = ~hit_lvl;
      cyc($urandom_range(0, 149) != 0, $urandom_range(0, 2) == 0, hit_lvl, $urandom_range(0, 39) == 0);
    end
    model_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
